// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Brief    : Shared pixel types and pipeline latencies for the filter chain.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned MATRIX_LAT     = 2;
  localparam int unsigned MEDIAN_LAT     = 3;

  typedef logic [DEFAULT_DATA_W-1:0] pixel_t;

  // Border flags captured alongside each accepted pixel
  typedef struct packed {
    logic row1_off;
    logic row2_off;
    logic col_first;
    logic col_second;
  } win_mask_t;

endpackage
`default_nettype wire

// File: rtl/line_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : line_buf_ram
// Brief    : One-line pixel store, single write port, synchronous read-old.
// Revision : 1.0 - initial release
// ============================================================================
module line_buf_ram #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/matrix_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : matrix_3x3_gen
// Brief    : Two-line buffered 3x3 neighbourhood generator for raster video.
// Options  : MATRIX_BORDER_REPLICATE_EN - borders copy nearest pixel, not 0
// Revision : 1.0 - initial release
// ============================================================================
module matrix_3x3_gen
  import pixel_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int COL_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);

  logic              w_accept;
  logic              w_href_fall;
  logic              w_wr_en;
  logic              r_href_d;
  logic [COL_W-1:0]  r_col_cnt;
  logic [1:0]        r_row_cnt;
  logic              r_col_ovf;

  logic              r_acc_d;
  logic [DATA_W-1:0] r_pix;
  win_mask_t         w_mask;
  win_mask_t         r_mask;
  logic              r_wr0_en;
  logic [COL_W-1:0]  r_wr0_addr;

  logic [DATA_W-1:0] w_buf0_q;
  logic [DATA_W-1:0] w_buf1_q;

  logic [DATA_W-1:0] r_win [3][3];
  logic [DATA_W-1:0] w_new [3];
  logic [DATA_W-1:0] w_c0  [3];
  logic [DATA_W-1:0] w_c1  [3];

  logic [MATRIX_LAT-1:0] r_vs_pipe;
  logic [MATRIX_LAT-1:0] r_hr_pipe;
  logic [MATRIX_LAT-1:0] r_ce_pipe;

  assign w_accept    = per_frame_clken & per_frame_href;
  assign w_href_fall = r_href_d & ~per_frame_href;
  // Pixels past the end of a long line still shift the window but are not stored
  assign w_wr_en     = w_accept & ~r_col_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_d  <= 1'b0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_col_ovf <= 1'b0;
    end else begin
      r_href_d <= per_frame_href;
      if (per_frame_vsync) begin
        r_col_cnt <= '0;
        r_row_cnt <= '0;
        r_col_ovf <= 1'b0;
      end else if (w_href_fall) begin
        r_col_cnt <= '0;
        r_col_ovf <= 1'b0;
        if (r_row_cnt != 2'd2) begin
          r_row_cnt <= r_row_cnt + 2'd1;
        end
      end else if (w_accept) begin
        if (r_col_cnt == c_col_last) begin
          r_col_ovf <= 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_mask            = '0;
    w_mask.row1_off   = (r_row_cnt != 2'd2) | r_col_ovf;
    w_mask.row2_off   = (r_row_cnt == 2'd0) | r_col_ovf;
    w_mask.col_first  = (r_col_cnt == '0);
    w_mask.col_second = (r_col_cnt == COL_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_d    <= 1'b0;
      r_pix      <= '0;
      r_mask     <= '0;
      r_wr0_en   <= 1'b0;
      r_wr0_addr <= '0;
    end else begin
      r_acc_d    <= w_accept;
      r_pix      <= per_img_y;
      r_mask     <= w_mask;
      r_wr0_en   <= w_wr_en;
      r_wr0_addr <= r_col_cnt;
    end
  end

  // buf1 holds line N-1; its displaced word migrates into buf0 one cycle later
  line_buf_ram #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_buf1 (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (r_col_cnt),
    .wdata (per_img_y),
    .re    (w_accept),
    .raddr (r_col_cnt),
    .rdata (w_buf1_q)
  );

  line_buf_ram #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_buf0 (
    .clk   (clk),
    .we    (r_wr0_en),
    .waddr (r_wr0_addr),
    .wdata (w_buf1_q),
    .re    (w_accept),
    .raddr (r_col_cnt),
    .rdata (w_buf0_q)
  );

  always_comb begin
    w_new[2] = r_pix;
`ifdef MATRIX_BORDER_REPLICATE_EN
    w_new[1] = r_mask.row2_off ? r_pix : w_buf1_q;
    w_new[0] = r_mask.row2_off ? r_pix : (r_mask.row1_off ? w_buf1_q : w_buf0_q);
`else
    w_new[1] = r_mask.row2_off ? '0 : w_buf1_q;
    w_new[0] = r_mask.row1_off ? '0 : w_buf0_q;
`endif
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_c0[r] = r_win[r][1];
      w_c1[r] = r_win[r][2];
      if (r_mask.col_first) begin
`ifdef MATRIX_BORDER_REPLICATE_EN
        w_c0[r] = w_new[r];
        w_c1[r] = w_new[r];
`else
        w_c0[r] = '0;
        w_c1[r] = '0;
`endif
      end else if (r_mask.col_second) begin
`ifdef MATRIX_BORDER_REPLICATE_EN
        w_c0[r] = r_win[r][1];  // already a copy of the first pixel
`else
        w_c0[r] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (r_acc_d) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= w_c0[r];
        r_win[r][1] <= w_c1[r];
        r_win[r][2] <= w_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_pipe <= '0;
      r_hr_pipe <= '0;
      r_ce_pipe <= '0;
    end else begin
      r_vs_pipe <= {r_vs_pipe[MATRIX_LAT-2:0], per_frame_vsync};
      r_hr_pipe <= {r_hr_pipe[MATRIX_LAT-2:0], per_frame_href};
      r_ce_pipe <= {r_ce_pipe[MATRIX_LAT-2:0], per_frame_clken};
    end
  end

  assign matrix_frame_vsync = r_vs_pipe[MATRIX_LAT-1];
  assign matrix_frame_href  = r_hr_pipe[MATRIX_LAT-1];
  assign matrix_frame_clken = r_ce_pipe[MATRIX_LAT-1];

  assign matrix_p11 = r_win[0][0];
  assign matrix_p12 = r_win[0][1];
  assign matrix_p13 = r_win[0][2];
  assign matrix_p21 = r_win[1][0];
  assign matrix_p22 = r_win[1][1];
  assign matrix_p23 = r_win[1][2];
  assign matrix_p31 = r_win[2][0];
  assign matrix_p32 = r_win[2][1];
  assign matrix_p33 = r_win[2][2];

endmodule
`default_nettype wire

// File: tb/tb_matrix_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_3x3_gen
// Brief    : Directed bench for matrix_3x3_gen at IMG_WIDTH=4.
// Options  : MATRIX_BORDER_REPLICATE_EN - switches border expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_3x3_gen;
  import pixel_pkg::*;

`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   vs    = 1'b0;
  logic   hr    = 1'b0;
  logic   ce    = 1'b0;
  pixel_t y     = '0;

  logic   mvs, mhr, mce;
  pixel_t p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [71:0] win;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_3x3_gen #(
    .IMG_WIDTH (4),
    .DATA_W    (8),
    .COL_W     (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (vs),
    .per_frame_href     (hr),
    .per_frame_clken    (ce),
    .per_img_y          (y),
    .matrix_frame_vsync (mvs),
    .matrix_frame_href  (mhr),
    .matrix_frame_clken (mce),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33)
  );

  assign win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  task automatic tick(input logic v, input logic h, input logic c, input pixel_t d);
    @(negedge clk);
    vs = v;
    hr = h;
    ce = c;
    y  = d;
  endtask

  task automatic px(input int d);
    tick(1'b0, 1'b1, 1'b1, 8'(d));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int a11, input int a12, input int a13,
                                     input int a21, input int a22, input int a23,
                                     input int a31, input int a32, input int a33);
    return {8'(a11), 8'(a12), 8'(a13), 8'(a21), 8'(a22), 8'(a23),
            8'(a31), 8'(a32), 8'(a33)};
  endfunction

  initial begin
    // Power-on reset
    repeat (3) idle();
    chk("reset_win", win, '0);
    chk("reset_qual", {69'd0, mvs, mhr, mce}, '0);
    rst_n = 1'b1;

    // Frame 1: vsync qualifier delay
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    idle();
    chk("vsync_delay_on", {71'd0, mvs}, 72'd1);
    idle();
    idle();
    chk("vsync_delay_off", {71'd0, mvs}, 72'd0);

    // Line 1 (row_cnt=0): rows 1 and 2 masked
    px(1); px(2); px(3); px(4);
    idle();
    chk("line1_px3", win, w9(REP ? 1 : 0, REP ? 2 : 0, REP ? 3 : 0,
                             REP ? 1 : 0, REP ? 2 : 0, REP ? 3 : 0, 1, 2, 3));
    chk("line1_qual", {70'd0, mhr, mce}, 72'd3);
    idle();

    // Line 2 (row_cnt=1): row 1 masked
    px(5); px(6); px(7); px(8);
    idle(); idle();
    chk("line2_px8", win, w9(REP ? 2 : 0, REP ? 3 : 0, REP ? 4 : 0, 2, 3, 4, 6, 7, 8));

    // Line 3: first column clears/replicates, last column full window
    px(9); px(10); px(11);
    chk("line3_col0", win, w9(REP ? 1 : 0, REP ? 1 : 0, 1,
                              REP ? 5 : 0, REP ? 5 : 0, 5,
                              REP ? 9 : 0, REP ? 9 : 0, 9));
    px(12);
    idle(); idle();
    chk("line3_px12", win, w9(2, 3, 4, 6, 7, 8, 10, 11, 12));

    // Line 4: clken gaps 1,0,1,1
    tick(1'b0, 1'b1, 1'b1, 8'd13);
    tick(1'b0, 1'b1, 1'b0, 8'd99);
    px(14);
    chk("gap_t2_clken", {71'd0, mce}, 72'd1);
    chk("gap_t2_p33", {64'd0, p33}, 72'd13);
    px(15);
    chk("gap_t3_clken", {71'd0, mce}, 72'd0);
    chk("gap_t3_p33", {64'd0, p33}, 72'd13);
    idle();
    chk("gap_t4_clken", {71'd0, mce}, 72'd1);
    chk("gap_t4_p32_p33", {56'd0, p32, p33}, {56'd0, 8'd13, 8'd14});
    idle();
    chk("gap_t5_clken", {71'd0, mce}, 72'd1);
    chk("gap_t5_win", win, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // clken without href: qualifier passes, window holds
    tick(1'b0, 1'b0, 1'b1, 8'd77);
    idle();
    idle();
    chk("stray_clken", {71'd0, mce}, 72'd1);
    chk("stray_hold", win, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    idle();
    chk("stray_clken_off", {71'd0, mce}, 72'd0);

    // Frame 2: long line behaviour
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    idle();
    px(21); px(22); px(23); px(24);
    idle(); idle();
    px(31); px(32); px(33); px(34); px(35); px(36);
    idle(); idle();
    chk("long_line_tail", win, w9(REP ? 24 : 0, REP ? 35 : 0, REP ? 36 : 0,
                                  24, REP ? 35 : 0, REP ? 36 : 0, 34, 35, 36));
    px(41); px(42); px(43); px(44);
    idle(); idle();
    chk("after_long_line", win, w9(22, 23, 24, 32, 33, 34, 42, 43, 44));

    // Reset mid-line
    px(51); px(52); px(53);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 8'd54);
    tick(1'b0, 1'b1, 1'b1, 8'd55);
    chk("midreset_win", win, '0);
    chk("midreset_qual", {69'd0, mvs, mhr, mce}, '0);
    idle();
    rst_n = 1'b1;
    idle();
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    idle();
    px(61); px(62); px(63);
    chk("newframe_col0", win, w9(REP ? 61 : 0, REP ? 61 : 0, REP ? 61 : 0,
                                 REP ? 61 : 0, REP ? 61 : 0, REP ? 61 : 0,
                                 REP ? 61 : 0, REP ? 61 : 0, 61));
    px(64);
    idle(); idle();
    chk("newframe_px64", win, w9(REP ? 62 : 0, REP ? 63 : 0, REP ? 64 : 0,
                                 REP ? 62 : 0, REP ? 63 : 0, REP ? 64 : 0,
                                 62, 63, 64));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_3x3_gen.md
Name: matrix_3x3_gen

Overview:
- Upstream neighbour of the 3x3 median filter stage.
- Accepts a raster stream of 8-bit grey pixels with vsync/href/clken qualifiers.
- Buffers the two previous lines and emits a 3x3 neighbourhood (p11..p33) with frame qualifiers delayed to match.
- Outputs connect one-to-one to the median filter's data11..data33 and frame_vsync/href/clken inputs.

Parameters:
IMG_WIDTH, 640, active pixels per line; sets line-buffer depth and column counter range
DATA_W, 8, pixel width in bits
COL_W, 10, column/row counter width; must satisfy 2^COL_W >= IMG_WIDTH

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  frame sync, active high
per_frame_href  in  1  line valid, active high
per_frame_clken  in  1  pixel strobe; pixel valid only when href=1
per_img_y  in  DATA_W  input pixel
matrix_frame_vsync  out  1  vsync delayed by 2 cycles
matrix_frame_href  out  1  href delayed by 2 cycles
matrix_frame_clken  out  1  clken delayed by 2 cycles
matrix_p11..matrix_p13  out  DATA_W each  oldest row (line N-2), left to right
matrix_p21..matrix_p23  out  DATA_W each  line N-1, left to right
matrix_p31..matrix_p33  out  DATA_W each  current line N, left to right

Behaviour:
- One clock domain: clk. Asynchronous active-low reset: rst_n.
- Reset clears all outputs, counters, window registers and qualifier delay lines to 0. RAM contents are not cleared; stale data is masked by row_cnt.
- Pixel accept: clken=1 and href=1. Clken while href=0 is ignored for data; it is still delayed through the qualifier pipe.
- col_cnt:
  - Increments on each accepted pixel.
  - Clears on href falling edge and while vsync=1.
  - Saturates at IMG_WIDTH-1. Extra pixels in a long line do not write the RAMs; they shift the window using zero rows 1 and 2.
- row_cnt:
  - Increments on href falling edge; saturates at 2.
  - Clears while vsync=1.
- Line buffers: two DATA_W x IMG_WIDTH RAMs, each with synchronous read and write-first=false (read returns old data).
  - On accept at address col_cnt: buf1 writes the pixel; buf0 writes buf1's old word.
  - Read data gives line N-1 (buf1) and line N-2 (buf0) at the same column.
- Pipeline:
  - Cycle 1: register pixel, issue RAM reads, register the masks.
  - Cycle 2: shift the window left by one column on the delayed accept; new right column = {buf0 out, buf1 out, pixel}.
  - Latency: accepted pixel appears at p33 exactly 2 cycles later, coincident with matrix_frame_clken=1.
  - p22 is therefore spatially (row-1, col-1) of the newest pixel. Downstream accepts this offset.
- Border masking (default, zero fill):
  - row_cnt=0: row1 and row2 columns load 0.
  - row_cnt=1: row1 loads 0.
  - At col_cnt=0: window columns 1 and 2 clear to 0 before the new right column loads.
  - At col_cnt=1: column 1 is 0.
- Qualifiers: 2-stage shift registers for vsync/href/clken, independent of data.
- Simultaneous events:
  - href falling edge coincident with the last clken: the pixel is accepted first, then col_cnt clears.
  - vsync=1 overrides all counter increments.
- Reset mid-frame: the block restarts cleanly. The first output line after the next vsync follows row_cnt=0 masking.

Optional Feature:
- Macro: MATRIX_BORDER_REPLICATE_EN.
- Defined: masked positions replicate the nearest valid pixel instead of 0.
  - Row1 copies row2 when row_cnt=1; row1 and row2 copy row3 when row_cnt=0.
  - At line start, columns 1 and 2 copy the new right column.
- Undefined: zero fill as above. Latency is unchanged in both builds.

Decomposition:
- Shared package pixel_pkg:
  - DATA_W default.
  - Pixel typedef.
  - Pipeline latency constant MATRIX_LAT=2; the median stage adds 3.
- One sub-module: line_buf_ram (single-port-write / sync-read RAM, DATA_W x IMG_WIDTH), instantiated twice.
- Counters, masking and window registers stay in the top.

Test Plan:
- IMG_WIDTH=4, 3 lines of pixels 1..12, zero fill:
  - 4th pixel of line 3 (value 12) → 2 cycles later p31..p33=10,11,12; p21..p23=6,7,8; p11..p13=2,3,4.
- First line, pixel value 3 → p1x=p2x=0, p33=3; line 2 → p1x=0.
- Reset asserted mid-line 2, released, then vsync and a new frame → outputs 0 during reset; first line of the new frame has zero rows 1 and 2 despite stale RAM.
- Qualifier alignment with clken gaps (pattern 1,0,1,1) → matrix_frame_clken reproduces 1,0,1,1 shifted exactly 2 cycles; the window shifts only on 1s.
- Line of 6 pixels with IMG_WIDTH=4 → pixels 5 and 6 produce outputs with rows 1 and 2 = 0; the next line's data reads the correct 4 stored pixels.
- MATRIX_BORDER_REPLICATE_EN defined, first line pixel 7 at col 0 → all nine outputs = 7.
